// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring divider, one quotient bit per clock.
// Shifts {A,Q} left and subtracts the divisor, restoring on a negative result.
// Optional feature macro: DIV_ZERO_DETECT_EN (short-circuits divisor==0 and raises dbz).
module shift_sub_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    count;

  logic [WIDTH+1:0] a_sh;
  logic [WIDTH+1:0] diff;
  logic             neg;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;

  // One restoring iteration: shift {A,Q} left, trial-subtract M, restore if negative.
  // The extra top bit keeps the sign of the trial subtraction without losing a borrow.
  always_comb begin
    a_sh  = {a_r, q_r[WIDTH-1]};
    diff  = a_sh - (WIDTH+2)'(m_r);
    neg   = diff[WIDTH+1];
    a_nxt = neg ? a_sh[WIDTH:0] : diff[WIDTH:0];
    q_nxt = {q_r[WIDTH-2:0], ~neg};
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_r;
  assign dbz = dbz_r;
`else
  assign dbz = 1'b0;
`endif

  // Control FSM and datapath registers; busy/done are registered one cycle behind the state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      count     <= '0;
      a_r       <= '0;
      q_r       <= '0;
      m_r       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_r     <= 1'b0;
`endif
    end else begin
      busy <= (state == RUN);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= '0;
            q_r   <= dividend;
            m_r   <= divisor;
            count <= CW'(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
            dbz_r <= 1'b0;
            state <= (divisor == '0) ? ZERO : RUN;
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          a_r   <= a_nxt;
          q_r   <= q_nxt;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= DONE;
            quotient  <= q_nxt;
            remainder <= a_nxt[WIDTH-1:0];
          end
        end
`ifdef DIV_ZERO_DETECT_EN
        ZERO: begin
          state     <= DONE;
          quotient  <= '1;
          remainder <= q_r;
          dbz_r     <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider at WIDTH=4.
module tb_shift_sub_divider;

  localparam int unsigned W = 4;

  logic         clk;
  logic         clr;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int checks = 0;
  int errors = 0;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dd;
    int dv;
    int q;
    int r;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one edge, then wait (bounded) for done; report latency and busy cycles.
  task automatic run_div(input int dd, input int dv, output int lat, output int bcnt,
                         output int got);
    dividend = W'(dd);
    divisor  = W'(dv);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    got  = 0;
    for (int k = 1; k <= 20 && got == 0; k++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        lat = k;
      end
    end
  endtask

  task automatic check_result(input string name, input int dd, input int dv,
                              input int eq, input int er, input int elat,
                              input int ebusy, input int edbz);
    int lat, bcnt, got;
    run_div(dd, dv, lat, bcnt, got);
    check({name, "_done_seen"}, got, 1);
    check({name, "_latency"}, lat, elat);
    check({name, "_busy_cycles"}, bcnt, ebusy);
    check({name, "_q"}, int'(quotient), eq);
    check({name, "_r"}, int'(remainder), er);
    check({name, "_dbz"}, int'(dbz), edbz);
    @(posedge clk); #1;
    check({name, "_done_pulse_len"}, int'(done), 0);
  endtask

  vec_t vecs[6];
  int   lat, bcnt, got, npulse;

  initial begin
    vecs[0] = '{13, 4, 3, 1};
    vecs[1] = '{15, 1, 15, 0};
    vecs[2] = '{3, 7, 0, 3};
    vecs[3] = '{15, 15, 1, 0};
    vecs[4] = '{0, 5, 0, 0};
    vecs[5] = '{11, 3, 3, 2};

    clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dbz", int'(dbz), 0);

    // Main vector table.
    for (int i = 0; i < 6; i++) begin
      check_result($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv,
                   vecs[i].q, vecs[i].r, 5, 4, 0);
    end

    // Result holds in IDLE with new operands on the inputs.
    dividend = 4'd7; divisor = 4'd2;
    repeat (4) @(posedge clk); #1;
    check("hold_q", int'(quotient), 3);
    check("hold_r", int'(remainder), 2);
    check("hold_busy", int'(busy), 0);

    // Start re-pulsed mid-run with different operands is ignored.
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    npulse = 0; got = 0; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin
        dividend = 4'd15; divisor = 4'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (got == 0) begin
          got = 1;
          lat = k;
          check("restart_q", int'(quotient), 4);
          check("restart_r", int'(remainder), 1);
        end
      end
    end
    start = 1'b0;
    check("restart_done_seen", got, 1);
    check("restart_latency", lat, 5);
    check("restart_pulses", npulse, 1);

    // Clear mid-run aborts with no done.
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_q", int'(quotient), 0);
    check("abort_r", int'(remainder), 0);
    npulse = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) npulse++;
    end
    check("abort_no_activity", npulse, 0);
    check_result("after_abort", 14, 3, 4, 2, 5, 4, 0);

    // Divide by zero.
`ifdef DIV_ZERO_DETECT_EN
    check_result("divzero", 10, 0, 15, 10, 2, 0, 1);
    check("divzero_dbz_held", int'(dbz), 1);
    check_result("after_divzero", 13, 4, 3, 1, 5, 4, 0);
`else
    check_result("divzero", 10, 0, 15, 10, 5, 4, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
